// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Holds the memory-wait FSM states, forward-mux selects and the load marker.
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } mem_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Memory stage wins over writeback because it holds the younger result.
  function automatic logic [1:0] fwd_select(
    input logic                 wr_m,
    input logic [REG_IDX_W-1:0] rd_m,
    input logic                 wr_w,
    input logic [REG_IDX_W-1:0] rd_w,
    input logic [REG_IDX_W-1:0] rs
  );
    if (wr_m && (rd_m != '0) && (rd_m == rs)) return FWD_M;
    if (wr_w && (rd_w != '0) && (rd_w == rs)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Tracks an outstanding data-memory access, counts wait cycles and latches
// a sticky timeout error; the stall request is combinational from state.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  mem_state_t        state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              mem_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg >= WAIT_LAST) begin
            // >= keeps tiny MEM_TIMEOUT values from wrapping past the limit
            state_reg   <= ERR;
            mem_err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        ERR: begin
          mem_err_reg <= 1'b1;
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_stall = 1'b0;
    case (state_reg)
      RUN:      mem_stall = mem_req && !mem_ready;
      MEM_WAIT: mem_stall = !mem_ready;
      default:  mem_stall = 1'b1;
    endcase
  end

  assign mem_err = mem_err_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall, branch flush, load-use/RAW
// stall and operand forwarding. Define HAZARD_FORWARDING_EN to enable forwarding.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1_D,
  input  logic [4:0]           Rs2_D,
  input  logic [4:0]           Rs1_E,
  input  logic [4:0]           Rs2_E,
  input  logic [4:0]           Rd_E,
  input  logic [4:0]           Rd_M,
  input  logic [4:0]           Rd_W,
  input  logic                 regWrite_E,
  input  logic                 regWrite_M,
  input  logic                 regWrite_W,
  input  logic [1:0]           resultSrc_E,
  input  logic                 PCsrc_E,
  input  logic                 memReq_M,
  input  logic                 memReady_M,
  output logic                 stall_F,
  output logic                 stall_D,
  output logic                 stall_E,
  output logic                 stall_M,
  output logic                 flush_D,
  output logic                 flush_E,
  output logic                 flush_W,
  output logic [1:0]           forwardA_E,
  output logic [1:0]           forwardB_E,
  output logic                 memErr,
  output logic [CNT_WIDTH-1:0] stallCnt
);

  logic                 mem_stall;
  logic                 data_hazard;
  logic [1:0]           load_use_hit;
  logic [1:0]           raw_hit;
  logic [4:0]           rs_d [2];
  logic [4:0]           rs_e [2];
  logic [1:0]           fwd_sel [2];
  logic [CNT_WIDTH-1:0] stall_cnt_reg;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (memReq_M),
    .mem_ready(memReady_M),
    .mem_stall(mem_stall),
    .mem_err  (memErr)
  );

  assign rs_d[0] = Rs1_D;
  assign rs_d[1] = Rs2_D;
  assign rs_e[0] = Rs1_E;
  assign rs_e[1] = Rs2_E;

  // One detector per source operand; index 0 is rs1, index 1 is rs2.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign load_use_hit[gi] = (resultSrc_E == RESULT_SRC_LOAD) &&
                              (Rd_E != 5'd0) && (Rd_E == rs_d[gi]);
`ifdef HAZARD_FORWARDING_EN
    assign fwd_sel[gi] = fwd_select(regWrite_M, Rd_M, regWrite_W, Rd_W, rs_e[gi]);
    assign raw_hit[gi] = 1'b0;
`else
    // Without bypass paths any pending E/M write must drain before decode reads.
    assign raw_hit[gi] = (rs_d[gi] != 5'd0) &&
                         ((regWrite_E && (Rd_E == rs_d[gi])) ||
                          (regWrite_M && (Rd_M == rs_d[gi])));
    assign fwd_sel[gi] = FWD_RF;
`endif
  end

`ifdef HAZARD_FORWARDING_EN
  logic unused_raw_inputs;
  assign unused_raw_inputs = regWrite_E;
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs_e[0], rs_e[1], Rd_W, regWrite_W};
`endif

  assign data_hazard = (|load_use_hit) || (|raw_hit);
  assign forwardA_E  = fwd_sel[0];
  assign forwardB_E  = fwd_sel[1];

  // Memory wait freezes everything, so a redirect or load-use waits behind it.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (mem_stall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else if (PCsrc_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (data_hazard) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_F && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign stallCnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations are queued as stimulus is
// driven and popped when the outputs are sampled on the falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic        regWrite_E, regWrite_M, regWrite_W;
  logic [1:0]  resultSrc_E;
  logic        PCsrc_E, memReq_M, memReady_M;
  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_W;
  logic [1:0]  forwardA_E, forwardB_E;
  logic        memErr;
  logic [31:0] stallCnt;

  hazard_ctrl #(
    .MEM_TIMEOUT(16),
    .CNT_WIDTH  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1_D      (Rs1_D),
    .Rs2_D      (Rs2_D),
    .Rs1_E      (Rs1_E),
    .Rs2_E      (Rs2_E),
    .Rd_E       (Rd_E),
    .Rd_M       (Rd_M),
    .Rd_W       (Rd_W),
    .regWrite_E (regWrite_E),
    .regWrite_M (regWrite_M),
    .regWrite_W (regWrite_W),
    .resultSrc_E(resultSrc_E),
    .PCsrc_E    (PCsrc_E),
    .memReq_M   (memReq_M),
    .memReady_M (memReady_M),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .stall_E    (stall_E),
    .stall_M    (stall_M),
    .flush_D    (flush_D),
    .flush_E    (flush_E),
    .flush_W    (flush_W),
    .forwardA_E (forwardA_E),
    .forwardB_E (forwardB_E),
    .memErr     (memErr),
    .stallCnt   (stallCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rw_e, rw_m, rw_w;
    logic [1:0] rsrc;
    logic       pcsrc, req, ready;
  } stim_t;

  typedef struct {
    string       name;
    logic [10:0] v;
    logic        err;
  } exp_t;

  // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, fwdA, fwdB}
  localparam logic [10:0] V_NONE = 11'b0000_000_0000;
  localparam logic [10:0] V_HAZ  = 11'b1100_010_0000;
  localparam logic [10:0] V_MEM  = 11'b1111_001_0000;
  localparam logic [10:0] V_BR   = 11'b0000_110_0000;

  exp_t        exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          exp_cnt      = 0;
  logic [10:0] obs;

  assign obs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
                forwardA_E, forwardB_E};

  function automatic stim_t idle_stim();
    return '0;
  endfunction

  task automatic apply(input stim_t s);
    Rs1_D = s.rs1_d; Rs2_D = s.rs2_d; Rs1_E = s.rs1_e; Rs2_E = s.rs2_e;
    Rd_E = s.rd_e; Rd_M = s.rd_m; Rd_W = s.rd_w;
    regWrite_E = s.rw_e; regWrite_M = s.rw_m; regWrite_W = s.rw_w;
    resultSrc_E = s.rsrc; PCsrc_E = s.pcsrc;
    memReq_M = s.req; memReady_M = s.ready;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e, got;
    for (int i = 0; i < 3; i++) begin
      s = idle_stim();
      if (i == 0) begin
        apply(s);
      end else begin
        @(posedge clk); #1;
        if (i == 1) s.req = 1'b1;
        if (i == 2) rst = 1'b0;
        apply(s);
      end
      e.name = $sformatf("reset_c%0d", i);
      e.v    = (i == 1) ? V_MEM : V_NONE;
      e.err  = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      tests_run += 3;
      if (obs !== got.v) begin
        tests_failed++; $display("FAIL %s outputs: got %b want %b", got.name, obs, got.v);
      end
      if (memErr !== got.err) begin
        tests_failed++; $display("FAIL %s memErr: got %b want %b", got.name, memErr, got.err);
      end
      if (stallCnt !== 32'd0) begin
        tests_failed++; $display("FAIL %s stallCnt: got %0d want 0", got.name, stallCnt);
      end
      $display("[TB] %s outputs=%b memErr=%b stallCnt=%0d", got.name, obs, memErr, stallCnt);
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    exp_t  e, got;
    for (int i = 0; i < 2; i++) begin
      s = idle_stim();
      if (i == 0) begin
        s.rsrc = 2'b01; s.rd_e = 5'd5; s.rw_e = 1'b1; s.rs1_d = 5'd5;
      end
      @(posedge clk); #1; apply(s);
      e.name = $sformatf("load_use_c%0d", i);
      e.v    = (i == 0) ? V_HAZ : V_NONE;
      e.err  = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      tests_run += 3;
      if (obs !== got.v) begin
        tests_failed++; $display("FAIL %s outputs: got %b want %b", got.name, obs, got.v);
      end
      if (memErr !== got.err) begin
        tests_failed++; $display("FAIL %s memErr: got %b want %b", got.name, memErr, got.err);
      end
      if (stallCnt !== 32'(exp_cnt)) begin
        tests_failed++; $display("FAIL %s stallCnt: got %0d want %0d", got.name, stallCnt, exp_cnt);
      end
      $display("[TB] %s outputs=%b memErr=%b stallCnt=%0d", got.name, obs, memErr, stallCnt);
      if (got.v[10]) exp_cnt++;
    end
  endtask

`ifdef HAZARD_FORWARDING_EN
  task automatic test_forwarding();
    stim_t s;
    exp_t  e, got;
    for (int i = 0; i < 5; i++) begin
      s = idle_stim();
      e.v = V_NONE;
      case (i)
        0: begin s.rd_m = 5'd7; s.rd_w = 5'd7; s.rw_m = 1'b1; s.rw_w = 1'b1; s.rs1_e = 5'd7; e.v[3:2] = 2'b10; end
        1: begin s.rd_m = 5'd7; s.rd_w = 5'd7; s.rw_w = 1'b1; s.rs1_e = 5'd7; e.v[3:2] = 2'b01; end
        2: begin s.rw_m = 1'b1; s.rw_w = 1'b1; end
        3: begin s.rd_m = 5'd7; s.rw_m = 1'b1; s.rd_w = 5'd9; s.rw_w = 1'b1;
                 s.rs1_e = 5'd9; s.rs2_e = 5'd7; e.v[3:2] = 2'b01; e.v[1:0] = 2'b10; end
        default: begin s.rd_m = 5'd7; s.rd_w = 5'd7; s.rs2_e = 5'd7; end
      endcase
      @(posedge clk); #1; apply(s);
      e.name = $sformatf("forward_c%0d", i);
      e.err  = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      tests_run += 2;
      if (obs !== got.v) begin
        tests_failed++; $display("FAIL %s outputs: got %b want %b", got.name, obs, got.v);
      end
      if (stallCnt !== 32'(exp_cnt)) begin
        tests_failed++; $display("FAIL %s stallCnt: got %0d want %0d", got.name, stallCnt, exp_cnt);
      end
      $display("[TB] %s outputs=%b stallCnt=%0d", got.name, obs, stallCnt);
      if (got.v[10]) exp_cnt++;
    end
  endtask
`else
  task automatic test_raw_stall();
    stim_t s;
    exp_t  e, got;
    for (int i = 0; i < 6; i++) begin
      s = idle_stim();
      e.v = V_NONE;
      case (i)
        0: begin s.rd_m = 5'd3; s.rw_m = 1'b1; s.rs2_d = 5'd3;
                 s.rs1_e = 5'd3; s.rs2_e = 5'd3; s.rd_w = 5'd3; s.rw_w = 1'b1; e.v = V_HAZ; end
        1: begin s.rd_e = 5'd4; s.rw_e = 1'b1; s.rs1_d = 5'd4; e.v = V_HAZ; end
        2: begin s.rw_m = 1'b1; s.rw_e = 1'b1; end
        3: begin s.rd_w = 5'd6; s.rw_w = 1'b1; s.rs1_d = 5'd6; end
        4: begin s.rd_e = 5'd9; s.rs2_d = 5'd9; s.rd_m = 5'd9; end
        default: ;
      endcase
      @(posedge clk); #1; apply(s);
      e.name = $sformatf("raw_c%0d", i);
      e.err  = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      tests_run += 2;
      if (obs !== got.v) begin
        tests_failed++; $display("FAIL %s outputs: got %b want %b", got.name, obs, got.v);
      end
      if (stallCnt !== 32'(exp_cnt)) begin
        tests_failed++; $display("FAIL %s stallCnt: got %0d want %0d", got.name, stallCnt, exp_cnt);
      end
      $display("[TB] %s outputs=%b stallCnt=%0d", got.name, obs, stallCnt);
      if (got.v[10]) exp_cnt++;
    end
  endtask
`endif

  task automatic test_mem_wait();
    stim_t s;
    exp_t  e, got;
    for (int i = 0; i < 5; i++) begin
      s = idle_stim();
      s.req   = (i < 4);
      s.ready = (i == 3);
      @(posedge clk); #1; apply(s);
      e.name = $sformatf("mem_wait_c%0d", i);
      e.v    = (i < 3) ? V_MEM : V_NONE;
      e.err  = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      tests_run += 3;
      if (obs !== got.v) begin
        tests_failed++; $display("FAIL %s outputs: got %b want %b", got.name, obs, got.v);
      end
      if (memErr !== got.err) begin
        tests_failed++; $display("FAIL %s memErr: got %b want %b", got.name, memErr, got.err);
      end
      if (stallCnt !== 32'(exp_cnt)) begin
        tests_failed++; $display("FAIL %s stallCnt: got %0d want %0d", got.name, stallCnt, exp_cnt);
      end
      $display("[TB] %s outputs=%b memErr=%b stallCnt=%0d", got.name, obs, memErr, stallCnt);
      if (got.v[10]) exp_cnt++;
    end
  endtask

  task automatic test_priority();
    stim_t s;
    exp_t  e, got;
    for (int i = 0; i < 5; i++) begin
      s = idle_stim();
      if (i < 4) begin
        s.rsrc = 2'b01; s.rd_e = 5'd8; s.rw_e = 1'b1; s.rs1_d = 5'd8;
      end
      s.pcsrc = (i < 3);
      s.req   = (i == 1) || (i == 2);
      s.ready = (i == 2);
      case (i)
        0: e.v = V_BR;
        1: e.v = V_MEM;
        2: e.v = V_BR;
        3: e.v = V_HAZ;
        default: e.v = V_NONE;
      endcase
      @(posedge clk); #1; apply(s);
      e.name = $sformatf("priority_c%0d", i);
      e.err  = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      tests_run += 2;
      if (obs !== got.v) begin
        tests_failed++; $display("FAIL %s outputs: got %b want %b", got.name, obs, got.v);
      end
      if (stallCnt !== 32'(exp_cnt)) begin
        tests_failed++; $display("FAIL %s stallCnt: got %0d want %0d", got.name, stallCnt, exp_cnt);
      end
      $display("[TB] %s outputs=%b stallCnt=%0d", got.name, obs, stallCnt);
      if (got.v[10]) exp_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e, got;
    for (int i = 0; i < 5; i++) begin
      s = idle_stim();
      e.v = V_NONE;
      case (i)
        0: begin s.rsrc = 2'b01; s.rd_e = 5'd2; s.rw_e = 1'b1; s.rs2_d = 5'd2; e.v = V_HAZ; end
        1: begin s.rsrc = 2'b01; s.rd_e = 5'd2; s.rw_e = 1'b1; s.rs1_d = 5'd2; e.v = V_HAZ; end
        2: begin s.rsrc = 2'b01; s.rw_e = 1'b1; end
        3: begin s.req = 1'b1; s.ready = 1'b1; end
        default: ;
      endcase
      @(posedge clk); #1; apply(s);
      e.name = $sformatf("back_to_back_c%0d", i);
      e.err  = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      tests_run += 2;
      if (obs !== got.v) begin
        tests_failed++; $display("FAIL %s outputs: got %b want %b", got.name, obs, got.v);
      end
      if (stallCnt !== 32'(exp_cnt)) begin
        tests_failed++; $display("FAIL %s stallCnt: got %0d want %0d", got.name, stallCnt, exp_cnt);
      end
      $display("[TB] %s outputs=%b stallCnt=%0d", got.name, obs, stallCnt);
      if (got.v[10]) exp_cnt++;
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    exp_t  e, got;
    for (int i = 0; i < 20; i++) begin
      s = idle_stim();
      s.req   = (i < 16);
      s.ready = (i == 16) || (i == 17);
      @(posedge clk); #1;
      if (i == 18) begin
        rst     = 1'b1;
        exp_cnt = 0;
      end
      if (i == 19) rst = 1'b0;
      apply(s);
      e.name = $sformatf("timeout_c%0d", i);
      e.v    = (i < 18) ? V_MEM : V_NONE;
      e.err  = (i == 16) || (i == 17);
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      tests_run += 3;
      if (obs !== got.v) begin
        tests_failed++; $display("FAIL %s outputs: got %b want %b", got.name, obs, got.v);
      end
      if (memErr !== got.err) begin
        tests_failed++; $display("FAIL %s memErr: got %b want %b", got.name, memErr, got.err);
      end
      if (stallCnt !== 32'(exp_cnt)) begin
        tests_failed++; $display("FAIL %s stallCnt: got %0d want %0d", got.name, stallCnt, exp_cnt);
      end
      $display("[TB] %s outputs=%b memErr=%b stallCnt=%0d", got.name, obs, memErr, stallCnt);
      if (got.v[10] && (i < 18)) exp_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
`ifdef HAZARD_FORWARDING_EN
    test_forwarding();
`else
    test_raw_stall();
`endif
    test_mem_wait();
    test_priority();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: max cycles spent in MEM_WAIT before error.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: stall performance counter width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, each input, 5: register indices at the Decode, Execute, Memory and Writeback stages.
REQ-006 SHALL have ports regWrite_E, regWrite_M, regWrite_W, each input, 1: the stage's instruction writes Rd.
REQ-007 SHALL have port resultSrc_E, input, 2: the value 2'b01 marks a load.
REQ-008 SHALL have port PCsrc_E, input, 1: branch or jump taken in Execute.
REQ-009 SHALL have port memReq_M, input, 1: load/store active in Memory.
REQ-010 SHALL have port memReady_M, input, 1: data memory completes this cycle.
REQ-011 SHALL have ports stall_F, stall_D, stall_E, stall_M, each output, 1: hold the PC and the F/D, D/E, E/M pipeline registers.
REQ-012 SHALL have ports flush_D, flush_E, flush_W, each output, 1: the F/D, D/E, M/W pipeline registers load a bubble.
REQ-013 SHALL have ports forwardA_E, forwardB_E, each output, 2: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
REQ-014 SHALL have port memErr, output, 1: sticky memory timeout flag.
REQ-015 SHALL have port stallCnt, output, CNT_WIDTH: count of cycles with stall_F=1.

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT, ERR.
REQ-017 SHALL transition RUN->MEM_WAIT when memReq_M=1 and memReady_M=0; the wait counter loads 1.
REQ-018 SHALL, in MEM_WAIT, go to RUN on memReady_M=1, else increment the wait counter; when the counter equals MEM_TIMEOUT-1 and memReady_M=0, go to ERR.
REQ-019 SHALL make ERR terminal until rst; memErr=1 in ERR.
REQ-020 SHALL drive mem-wait stall combinationally (stall_F/D/E/M=1, flush_W=1) when (RUN and memReq_M and !memReady_M), in MEM_WAIT with memReady_M=0, or in ERR.
REQ-021 SHALL release the mem-wait stall in the same cycle memReady_M=1.
REQ-022 SHALL detect load-use when resultSrc_E=2'b01, Rd_E!=0, and Rd_E equals Rs1_D or Rs2_D; response: stall_F=1, stall_D=1, flush_E=1.
REQ-023 SHALL, on PCsrc_E=1, assert flush_D=1 and flush_E=1.
REQ-024 SHALL apply priority: mem-wait stall > PCsrc_E flush > load-use; a lower-priority cause is suppressed while a higher one is active.
REQ-025 SHALL compute forwardA_E: 10 if regWrite_M, Rd_M!=0 and Rd_M==Rs1_E; else 01 if regWrite_W, Rd_W!=0 and Rd_W==Rs1_E; else 00. forwardB_E is computed identically using Rs2_E.
REQ-026 SHALL increment stallCnt each cycle stall_F=1, saturating at all-ones.
REQ-027 SHALL keep all outputs other than stallCnt and memErr combinational from inputs and state.

Reset
REQ-028 SHALL, on rst asserted (asynchronous), set state=RUN, wait counter=0, stallCnt=0, memErr=0.
REQ-029 SHALL, in the reset cycle, drive all stall/flush outputs from RUN-state logic; a mid-wait reset abandons the access.

Configuration
REQ-030 SHALL, with macro HAZARD_FORWARDING_EN defined, forward per REQ-025.
REQ-031 SHALL, without HAZARD_FORWARDING_EN, tie forwardA_E and forwardB_E to 00 and add a RAW stall; it is raised when Rs1_D or Rs2_D (nonzero) equals Rd_E with regWrite_E, or Rd_M with regWrite_M; response as load-use; the register file resolves W-stage hazards by write-before-read.

Structure
REQ-032 SHALL place the state enum, the forward encodings (FWD_RF, FWD_W, FWD_M) and RESULT_SRC_LOAD=2'b01 in package hazard_pkg.
REQ-033 SHALL implement the FSM and wait counter in sub-module mem_wait_fsm; detection and forwarding logic stay in hazard_ctrl.

Verification
REQ-034 SHALL cover: lw x5 in E, Rs1_D=5 -> one cycle with stall_F=stall_D=flush_E=1; next cycle no stall; stallCnt=1.
REQ-035 SHALL cover: Rd_M=Rd_W=7, both regWrite=1, Rs1_E=7 -> forwardA_E=10; with regWrite_M=0 -> 01; with Rd=0 -> 00.
REQ-036 SHALL cover: memReq_M=1 with memReady_M low for 3 cycles, then high -> stalls and flush_W high 3 cycles, released in the ready cycle; state returns to RUN.
REQ-037 SHALL cover: memReady_M never rises, MEM_TIMEOUT=16 -> ERR and memErr=1 after 16 stalled cycles; stalls held until rst; rst clears memErr and stallCnt.
REQ-038 SHALL cover: PCsrc_E=1 coinciding with a load-use -> flush_D=flush_E=1, stall_F=0; with a mem-wait also active -> only the mem-wait response.
REQ-039 SHALL cover, without HAZARD_FORWARDING_EN: add x3 in M, Rs2_D=3 -> stall_F=stall_D=flush_E=1; forward outputs stay 00.
